// File: rtl/bram_uart_readback.sv
// Streams one stored vector (A or B) from BRAM out over UART TX, 8N1, LSB-first, low byte first.
// Latency: start -> done = 1 + BR_SIZE*(3 + 10*BAUD_DIV*NBITS/8) cycles; tx is registered.
// No backpressure: start is a one-cycle request, accepted only in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, sel            one-cycle read request; sel picks vector A (0) or B (1)
//   rd_addr, rd_en        shared BRAM read port, data valid one cycle after rd_en
//   rd_data_a, rd_data_b  BRAM read data for vectors A and B
//   tx                    UART serial out, idle high
//   busy, done            busy while streaming; done pulses once at the end
module bram_uart_readback #(
    parameter int BR_SIZE       = 1024,
    parameter int BR_WIDTH      = 10,
    parameter int NBITS         = 8,
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sel,
    output logic [BR_WIDTH-1:0] rd_addr,
    output logic                rd_en,
    input  logic [NBITS-1:0]    rd_data_a,
    input  logic [NBITS-1:0]    rd_data_b,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BYTES    = NBITS / 8;
    localparam int BIW      = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          state;
    logic                sel_q;
    logic [BR_WIDTH-1:0] addr;
    logic [NBITS-1:0]    shreg;
    logic [7:0]          cur_byte;
    logic [BIW-1:0]      byte_idx;
    logic [BCW-1:0]      baud_cnt;
    logic [3:0]          bit_cnt;
    logic                tx_q;

    // The byte on the wire always sits in the low 8 bits; higher bytes are shifted down.
    assign cur_byte = shreg[7:0];

    assign rd_addr = addr;
    assign rd_en   = (state == S_FETCH);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign tx      = tx_q;

    // tx_q is loaded with the level of the *next* bit period, so the line changes
    // exactly on the cycle a new bit begins. bit_cnt counts the bit currently on
    // the wire: 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sel_q    <= 1'b0;
            addr     <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        sel_q <= sel;
                        addr  <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    tx_q  <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    tx_q  <= 1'b1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shreg    <= sel_q ? rd_data_b : rd_data_a;
                    byte_idx <= '0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b0;          // start bit of the first frame
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (baud_cnt == BCW'(BAUD_DIV - 1)) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (byte_idx != BIW'(BYTES - 1)) begin
                                // Next byte of the same element follows with no gap.
                                shreg    <= shreg >> 8;
                                byte_idx <= byte_idx + 1'b1;
                                tx_q     <= 1'b0;
                            end else begin
                                // Idle-high gap (FETCH/WAIT/LOAD) stretches the stop bit.
                                tx_q <= 1'b1;
                                if (addr != BR_WIDTH'(BR_SIZE - 1)) begin
                                    addr  <= addr + 1'b1;
                                    state <= S_FETCH;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            // Entering bit bit_cnt+1: data bit bit_cnt for 0..7, stop for 8.
                            tx_q    <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_uart_readback.sv
// Testbench for bram_uart_readback: an 8-bit and a 16-bit instance, exercised one at a time.
// Expected frames/done times are queued at stimulus time; a UART monitor pops and compares.
// BRAM models return data one cycle after rd_en and hold it until the next read.
module tb_bram_uart_readback;

    localparam int CLKF = 1000000;
    localparam int BAUD = 100000;
    localparam int BD   = CLKF / BAUD;
    localparam int BRS  = 4;
    localparam int BRW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic           start8 = 1'b0, sel8 = 1'b0;
    logic [BRW-1:0] addr8;
    logic           rd_en8, tx8, busy8, done8;
    logic [7:0]     rda8 = '0, rdb8 = '0;
    logic [7:0]     a8[BRS], b8[BRS];

    // 16-bit instance
    logic           start16 = 1'b0, sel16 = 1'b0;
    logic [BRW-1:0] addr16;
    logic           rd_en16, tx16, busy16, done16;
    logic [15:0]    rda16 = '0, rdb16 = '0;
    logic [15:0]    a16[BRS], b16[BRS];

    bram_uart_readback #(.BR_SIZE(BRS), .BR_WIDTH(BRW), .NBITS(8),
                         .CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8),
        .rd_addr(addr8), .rd_en(rd_en8), .rd_data_a(rda8), .rd_data_b(rdb8),
        .tx(tx8), .busy(busy8), .done(done8));

    bram_uart_readback #(.BR_SIZE(BRS), .BR_WIDTH(BRW), .NBITS(16),
                         .CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sel(sel16),
        .rd_addr(addr16), .rd_en(rd_en16), .rd_data_a(rda16), .rd_data_b(rdb16),
        .tx(tx16), .busy(busy16), .done(done16));

    always @(posedge clk) begin
        if (rd_en8) begin
            rda8 <= a8[addr8];
            rdb8 <= b8[addr8];
        end
        if (rd_en16) begin
            rda16 <= a16[addr16];
            rdb16 <= b16[addr16];
        end
    end

    // Scoreboard
    typedef struct {
        logic [7:0] b;
        int         gap;   // idle cycles before this frame's start bit; -1 = first of vector
    } frame_t;

    frame_t fq[$];
    int     done_q[$];
    int     checks = 0, errors = 0, done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART monitor: samples every negedge; each bit must stay constant for BD samples.
    bit         active = 1'b0;
    int         bitn = 0, k = 0, start_cyc = 0, last_end = -1, rd_cnt = 0;
    logic       lvl = 1'b1, bad = 1'b0;
    logic [7:0] rx = '0;

    always @(negedge clk) begin : mon
        logic   tx_s;
        frame_t f;
        tx_s = tx8 & tx16;
        if (!rst_n) begin
            active   = 1'b0;
            last_end = -1;
            rd_cnt   = 0;
        end else begin
            if (rd_en8 | rd_en16) rd_cnt++;
            if (done8 | done16) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: actual done=1 required done=0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("rd_en_count", rd_cnt, BRS);
                end
                rd_cnt   = 0;
                last_end = -1;
            end
            if (!active && tx_s == 1'b0) begin
                active    = 1'b1;
                bitn      = 0;
                k         = 0;
                bad       = 1'b0;
                rx        = '0;
                start_cyc = cyc;
            end
            if (active) begin
                if (k == 0) lvl = tx_s;
                else if (tx_s !== lvl) bad = 1'b1;
                k++;
                if (k == BD) begin
                    k = 0;
                    if (bitn >= 1 && bitn <= 8) rx[bitn-1] = lvl;
                    if (bitn == 9) begin
                        if (lvl !== 1'b1) bad = 1'b1;
                        active = 1'b0;
                        if (fq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: actual byte %0h required none (cycle %0d)", rx, cyc);
                        end else begin
                            f = fq.pop_front();
                            check("frame_byte", rx, f.b);
                            check("frame_timing", bad, 1'b0);
                            if (f.gap >= 0 && last_end >= 0)
                                check("frame_gap", start_cyc - last_end - 1, f.gap);
                        end
                        last_end = cyc;
                    end
                    bitn++;
                end
            end
        end
    end

    task automatic drv(input bit wide, input bit v, input bit s);
        if (wide) begin
            start16 = v;
            sel16   = s;
        end else begin
            start8 = v;
            sel8   = s;
        end
    endtask

    // One read request. pokes: extra starts while busy and in the DONE cycle.
    // rst_at >= 0: assert async reset that many cycles after the start and abandon.
    task automatic run(input bit wide, input bit s, input bit pokes, input int rst_at);
        int          c, nb, exp_done, d0, rel;
        logic [15:0] v;
        frame_t      f;
        nb = wide ? 2 : 1;
        @(negedge clk);
        #1;
        c = cyc;
        for (int e = 0; e < BRS; e++) begin
            v = wide ? (s ? b16[e] : a16[e]) : {8'h00, (s ? b8[e] : a8[e])};
            for (int j = 0; j < nb; j++) begin
                f.b   = v[8*j +: 8];
                f.gap = (e == 0 && j == 0) ? -1 : ((j == 0) ? 3 : 0);
                fq.push_back(f);
            end
        end
        exp_done = c + 1 + BRS * (3 + 10 * BD * nb);
        if (rst_at < 0) done_q.push_back(exp_done);
        d0 = done_cnt;
        drv(wide, 1'b1, s);
        @(negedge clk);
        #1;
        drv(wide, 1'b0, 1'($urandom_range(0, 1)));
        check("busy_after_start", busy8 | busy16, 1'b1);
        check("rd_en_first", rd_en8 | rd_en16, 1'b1);
        check("rd_addr_first", wide ? 32'(addr16) : 32'(addr8), 0);
        while (done_cnt == d0 && cyc < exp_done + 20) begin
            @(negedge clk);
            #1;
            rel = cyc - c;
            if (rst_at >= 0 && rel == rst_at) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("tx_async_reset", tx8 & tx16, 1'b1);
                check("busy_async_reset", busy8 | busy16, 1'b0);
                fq.delete();
                done_q.delete();
                @(posedge clk);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                return;
            end
            drv(wide, pokes && (rel == 50 || rel == 200), 1'($urandom_range(0, 1)));
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual no done required done at cycle %0d", exp_done);
            fq.delete();
            done_q.delete();
            return;
        end
        // Now in the DONE cycle: a start here must be ignored.
        if (pokes) drv(wide, 1'b1, 1'($urandom_range(0, 1)));
        @(negedge clk);
        #1;
        drv(wide, 1'b0, 1'b0);
        check("busy_after_done", busy8 | busy16, 1'b0);
        check("done_one_cycle", done8 | done16, 1'b0);
        check("frames_left", fq.size(), 0);
    endtask

    initial begin
        a8[0] = 8'h55; a8[1] = 8'hA3; a8[2] = 8'h00; a8[3] = 8'hFF;
        for (int i = 0; i < BRS; i++) begin
            b8[i]  = 8'($urandom);
            a16[i] = 16'($urandom);
            b16[i] = 16'($urandom);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {tx8, tx16}, 2'b11);
        check("reset_busy", {busy8, busy16}, 2'b00);
        check("reset_done", {done8, done16}, 2'b00);
        check("reset_rd_en", {rd_en8, rd_en16}, 2'b00);
        check("reset_rd_addr", {addr8, addr16}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run(1'b0, 1'b0, 1'b1, -1);                 // 55,A3,00,FF with ignored starts
        b8[0] = 8'h01; b8[1] = 8'h02; b8[2] = 8'h03; b8[3] = 8'h04;
        run(1'b0, 1'b1, 1'b0, -1);                 // vector B selected
        run(1'b0, 1'b0, 1'b0, 150);                // reset in the middle of byte 2
        run(1'b0, 1'b0, 1'b0, -1);                 // full vector again from addr 0
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < BRS; j++) begin
                a8[j] = 8'($urandom);
                b8[j] = 8'($urandom);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        a16[0] = 16'hBEEF;
        run(1'b1, 1'b0, 1'b0, -1);                 // EF then BE back to back
        for (int j = 0; j < BRS; j++) begin
            a16[j] = 16'($urandom);
            b16[j] = 16'($urandom);
        end
        run(1'b1, 1'b1, 1'b1, -1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
